lb_bridge: RTL and testbench

Byte-stream to local-bus initiator. It parses command packets arriving as bytes from a host link (UART receiver), drives `lb_wr`, `lb_rd`, `lb_addr` and `lb_wr_d` into the local-bus targets (SUMP2 core, test registers), and collects `lb_rd_d` on `lb_rd_rdy`. Read data is returned MSB-first as bytes on a transmit handshake. It sits between the host UART and `core`, in the `clk_lb` domain.

---
 rtl/lb_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_lb_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_bridge.sv
// lb_bridge: byte-stream command parser driving a 32-bit local bus.
// Reads return MSB-first bytes over a busy-gated transmit strobe.
module lb_bridge #(
    parameter int unsigned rd_timeout   = 255,
    parameter int unsigned idle_timeout = 65535
) (
    input  logic        clk_lb,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_en,
    input  logic        tx_busy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_RCNT,
        S_WR, S_RD, S_RWAIT, S_TX
    } state_t;

    localparam logic [16:0] RD_TO   = 17'(rd_timeout);
    localparam logic [16:0] IDLE_TO = 17'(idle_timeout);

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [8:0]  rcnt_q, rcnt_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] idle_q, idle_d;
    logic        hold_q, hold_d;

    logic [16:0] idle_inc;
    logic        idle_exp;
    logic [7:0]  tx_sel;

    assign idle_inc = {1'b0, idle_q} + 17'd1;
    assign idle_exp = !rx_rdy && (idle_inc == IDLE_TO);

    assign lb_addr = addr_q;
    assign lb_wr_d = wdat_q;
    assign busy    = (state_q != S_IDLE);

    // Select the outgoing read-data byte, MSB first.
    always_comb begin
        tx_sel = 8'h00;
        unique case (bcnt_q)
            2'd0: tx_sel = rdat_q[31:24];
            2'd1: tx_sel = rdat_q[23:16];
            2'd2: tx_sel = rdat_q[15:8];
            2'd3: tx_sel = rdat_q[7:0];
            default: tx_sel = 8'h00;
        endcase
    end

    // Next-state and output decode for the packet parser and bus engine.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bcnt_d      = bcnt_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        rcnt_d      = rcnt_q;
        wait_d      = wait_q;
        idle_d      = idle_q;
        hold_d      = 1'b0;
        lb_wr       = 1'b0;
        lb_rd       = 1'b0;
        tx_en       = 1'b0;
        tx_byte     = 8'h00;
        timeout_err = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_rdy && rx_byte <= 8'h02) begin
                    cmd_d   = rx_byte[1:0];
                    bcnt_d  = 2'd0;
                    idle_d  = 16'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_rdy) begin
                    addr_d = {addr_q[23:0], rx_byte};
                    bcnt_d = bcnt_q + 2'd1;
                    idle_d = 16'd0;
                    if (bcnt_q == 2'd3) begin
                        state_d = (cmd_q == 2'd0) ? S_WDATA : S_RCNT;
                    end
                end else if (idle_exp) begin
                    idle_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_inc[15:0];
                end
            end
            S_WDATA: begin
                if (rx_rdy) begin
                    wdat_d = {wdat_q[23:0], rx_byte};
                    bcnt_d = bcnt_q + 2'd1;
                    idle_d = 16'd0;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WR;
                    end
                end else if (idle_exp) begin
                    idle_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_inc[15:0];
                end
            end
            S_RCNT: begin
                if (rx_rdy) begin
                    rcnt_d  = (rx_byte == 8'h00) ? 9'd256
                                                 : {1'b0, rx_byte};
                    idle_d  = 16'd0;
                    state_d = S_RD;
                end else if (idle_exp) begin
                    idle_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_inc[15:0];
                end
            end
            S_WR: begin
                lb_wr   = 1'b1;
                state_d = S_IDLE;
            end
            S_RD: begin
                lb_rd   = 1'b1;
                wait_d  = 16'd1;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (lb_rd_rdy) begin
                    rdat_d  = lb_rd_d;
                    bcnt_d  = 2'd0;
                    wait_d  = 16'd0;
                    state_d = S_TX;
                end else if ({1'b0, wait_q} >= RD_TO) begin
                    rdat_d      = 32'hFFFF_FFFF;
                    timeout_err = 1'b1;
                    bcnt_d      = 2'd0;
                    wait_d      = 16'd0;
                    state_d     = S_TX;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_TX: begin
                tx_byte = tx_sel;
                if (!hold_q && !tx_busy) begin
                    tx_en  = 1'b1;
                    hold_d = 1'b1;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        rcnt_d = rcnt_q - 9'd1;
                        if (rcnt_q == 9'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RD;
                            if (cmd_q == 2'd2) begin
                                addr_d = addr_q + 32'd4;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_lb or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= 2'd0;
            bcnt_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'd0;
            rcnt_q  <= 9'd0;
            wait_q  <= 16'd0;
            idle_q  <= 16'd0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            rcnt_q  <= rcnt_d;
            wait_q  <= wait_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_lb_bridge.sv
// tb_lb_bridge: randomized packets against a queue-based
// transaction model, bus target and transmitter model.
module tb_lb_bridge;

    localparam int RDTO = 16;
    localparam int IDTO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_rdy = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_busy;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d = 32'h0;
    logic        lb_rd_rdy = 1'b0;
    logic        busy;
    logic        timeout_err;

    logic busy_gen = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy = busy_gen | force_busy;

    lb_bridge #(
        .rd_timeout  (RDTO),
        .idle_timeout(IDTO)
    ) dut (
        .clk_lb     (clk),
        .reset      (rst_n),
        .rx_byte    (rx_byte),
        .rx_rdy     (rx_rdy),
        .tx_byte    (tx_byte),
        .tx_en      (tx_en),
        .tx_busy    (tx_busy),
        .lb_wr      (lb_wr),
        .lb_rd      (lb_rd),
        .lb_addr    (lb_addr),
        .lb_wr_d    (lb_wr_d),
        .lb_rd_d    (lb_rd_d),
        .lb_rd_rdy  (lb_rd_rdy),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int last_tx = -100;
    int n_terr = 0;
    int lat = -1;
    bit no_resp = 1'b0;
    bit fixed_dly = 1'b0;

    logic [63:0] obs_wr[$];
    logic [31:0] obs_rd[$];
    logic [7:0]  obs_tx[$];
    int          obs_txc[$];
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          exp_terr = 0;
    logic [31:0] resp_q[$];
    logic [31:0] exp_ovr[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] tdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus/transmit monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (lb_wr) obs_wr.push_back({lb_addr, lb_wr_d});
            if (lb_rd) obs_rd.push_back(lb_addr);
            if (timeout_err) n_terr++;
            if (tx_en) begin
                chk("tx_while_busy", 32'(tx_busy), 32'd0);
                chk("tx_gap", 32'((cyc - last_tx) >= 2), 32'd1);
                last_tx = cyc;
                obs_tx.push_back(tx_byte);
                obs_txc.push_back(cyc);
            end
        end
    end

    // Local-bus read target
    initial begin
        logic [31:0] d;
        int dly;
        forever begin
            @(negedge clk);
            if (rst_n && lb_rd && !no_resp) begin
                if (resp_q.size() > 0) d = resp_q.pop_front();
                else d = tdata(lb_addr);
                dly = fixed_dly ? 1 : int'($urandom_range(1, 6));
                repeat (dly) @(posedge clk);
                #1;
                lb_rd_d = d;
                lb_rd_rdy = 1'b1;
                @(posedge clk);
                #1;
                lb_rd_rdy = 1'b0;
                lb_rd_d = $urandom;
            end
        end
    end

    // Transmitter: busy for 1..3 cycles starting the cycle after tx_en
    initial forever begin
        @(negedge clk);
        if (tx_en) begin
            @(posedge clk);
            #1 busy_gen = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 busy_gen = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end 1 time unit after a posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_rdy = 1'b1;
        rx_cyc = cyc;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20000);
        chk("idle_reached", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_rd.delete();
        obs_tx.delete();
        obs_txc.delete();
        n_terr = 0;
    endtask

    task automatic compare(input string nm);
        chk({nm, " wr_n"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            chk({nm, " wr_addr"}, obs_wr[i][63:32], exp_wr[i][63:32]);
            chk({nm, " wr_data"}, obs_wr[i][31:0], exp_wr[i][31:0]);
        end
        chk({nm, " rd_n"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            chk({nm, " rd_addr"}, obs_rd[i], exp_rd[i]);
        chk({nm, " tx_n"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            chk({nm, " tx_byte"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
        chk({nm, " timeouts"}, 32'(n_terr), 32'(exp_terr));
        lat = (obs_txc.size() > 0) ? obs_txc[0] - rx_cyc : -1;
        exp_wr.delete();
        exp_rd.delete();
        exp_tx.delete();
        exp_terr = 0;
        clear_obs();
    endtask

    task automatic run_pkt(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdat, input logic [7:0] n,
                           input string nm);
        logic [7:0] b[$];
        logic [31:0] a, d;
        int cnt;
        b.push_back(cmd);
        for (int i = 3; i >= 0; i--) b.push_back(addr[8*i +: 8]);
        if (cmd == 8'h00) begin
            for (int i = 3; i >= 0; i--) b.push_back(wdat[8*i +: 8]);
            exp_wr.push_back({addr, wdat});
        end else begin
            b.push_back(n);
            cnt = (n == 8'h00) ? 256 : int'(n);
            a = addr;
            for (int k = 0; k < cnt; k++) begin
                exp_rd.push_back(a);
                if (no_resp) d = 32'hFFFF_FFFF;
                else if (exp_ovr.size() > 0) d = exp_ovr.pop_front();
                else d = tdata(a);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
                if (cmd == 8'h02) a = a + 32'd4;
            end
            if (no_resp) exp_terr = cnt;
        end
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            if (i + 1 < b.size())
                repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        if (cmd == 8'h00) begin
            @(negedge clk);
            chk({nm, " wr_strobe"}, 32'(lb_wr), 32'd1);
            chk({nm, " wr_addr_now"}, lb_addr, addr);
            chk({nm, " wr_data_now"}, lb_wr_d, wdat);
        end
        wait_idle();
        compare(nm);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " lb_wr"}, 32'(lb_wr), 32'd0);
        chk({nm, " lb_rd"}, 32'(lb_rd), 32'd0);
        chk({nm, " tx_en"}, 32'(tx_en), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " timeout_err"}, 32'(timeout_err), 32'd0);
        chk({nm, " lb_addr"}, lb_addr, 32'd0);
        chk({nm, " lb_wr_d"}, lb_wr_d, 32'd0);
        chk({nm, " tx_byte"}, 32'(tx_byte), 32'd0);
    endtask

    initial begin
        logic [7:0] c;
        logic [31:0] ad;
        int r;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_pkt(8'h00, 32'h0000_0008, 32'h1234_5678, 8'h00, "write");

        fixed_dly = 1'b1;
        resp_q = '{32'hA1, 32'hA2, 32'hA3};
        exp_ovr = '{32'hA1, 32'hA2, 32'hA3};
        run_pkt(8'h01, 32'h0000_0004, 32'h0, 8'h03, "rd_fixed");
        chk("rd_latency", 32'(lat), 32'd3);
        fixed_dly = 1'b0;

        run_pkt(8'h02, 32'hFFFF_FFFC, 32'h0, 8'h02, "rd_wrap");

        no_resp = 1'b1;
        run_pkt(8'h01, 32'h0000_0100, 32'h0, 8'h01, "rd_timeout");
        no_resp = 1'b0;

        send_byte(8'h7E);
        @(negedge clk);
        chk("junk_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h12);
        repeat (37) @(posedge clk);
        @(negedge clk);
        chk("resync_wait", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("resync_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        compare("resync");
        run_pkt(8'h00, 32'hDEAD_BEE0, 32'hCAFE_F00D, 8'h00, "post_sync");

        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                c = 8'($urandom_range(3, 255));
                send_byte(c);
                @(negedge clk);
                chk("rnd_junk", 32'(busy), 32'd0);
                @(posedge clk);
                #1;
            end else begin
                c = 8'(r % 3);
                ad = $urandom;
                if (r > 7) ad = 32'hFFFF_FFF0 | (ad & 32'hC);
                run_pkt(c, ad, $urandom, 8'($urandom_range(1, 4)), "rnd");
            end
        end

        run_pkt(8'h02, $urandom, 32'h0, 8'h00, "rd_256");

        no_resp = 1'b1;
        run_pkt(8'h00, 32'h0000_0040, 32'h0BAD_F00D, 8'h00, "pre_rst");
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        send_byte(8'h01);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_rwait");
        @(posedge clk);
        #1 rst_n = 1'b1;
        no_resp = 1'b0;
        clear_obs();

        force_busy = 1'b1;
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        send_byte(8'h02);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("tx_stalled", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_tx");
        @(posedge clk);
        #1 rst_n = 1'b1;
        force_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        run_pkt(8'h00, 32'h0000_0010, 32'h8765_4321, 8'h00, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
